// File: rtl/fpu_arbiter_if.sv
// fpu_arbiter_if: requester and response handshake bundle for fpu_arbiter.
//   req_valid[1:0] / req_ready[1:0] : per-requester valid/ready
//   req_a, req_b   : operands, [32i+31:32i] belongs to requester i
//   req_op         : opcodes, [2i+1:2i]; 00 ADD, 01 SUB, 10 DIV, 11 MUL
//   resp_valid / resp_ready : result handshake
//   resp_data, resp_id, resp_err : IEEE-754 single result, requester index, DIV flag
// master = issuing units plus result consumer; slave = the arbiter.
interface fpu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_op;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_id;
  logic        resp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, resp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, resp_err
  );
endinterface

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one fpu between two requesters.
// Round-robin grant in IDLE, registers the winning operands/opcode onto the
// fpu, waits FPU_LATENCY, captures fpu_o and returns it tagged with the
// requester id. DIV has no fpu datapath and is answered locally with a quiet
// NaN and resp_err=1.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : request/response handshakes, see fpu_arbiter_if
//   fpu_a, fpu_b      : registered operands to the fpu
//   fpu_opcode        : registered opcode to the fpu (passed unmodified)
//   fpu_o             : fpu result, valid FPU_LATENCY edges after stable inputs
//   busy              : high whenever not IDLE
module fpu_arbiter #(
  parameter int FPU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  fpu_arbiter_if.slave bus,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_opcode,
  input  logic [31:0] fpu_o,
  output logic        busy
);

  localparam int          CNT_W  = $clog2(FPU_LATENCY + 1) + 1;
  localparam logic [1:0]  OP_DIV = 2'b10;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic             id;
  logic [CNT_W-1:0] count;

  logic             any_req;
  logic             grant;
  logic [1:0]       grant_op;
  logic [31:0]      grant_a;
  logic [31:0]      grant_b;

  // Grant: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    any_req = |bus.req_valid;
    if (bus.req_valid == 2'b11) grant = ~last_grant;
    else                        grant = bus.req_valid[1];
    grant_op = grant ? bus.req_op[3:2]  : bus.req_op[1:0];
    grant_a  = grant ? bus.req_a[63:32] : bus.req_a[31:0];
    grant_b  = grant ? bus.req_b[63:32] : bus.req_b[31:0];
    bus.req_ready = 2'b00;
    if (state == IDLE && any_req) bus.req_ready = grant ? 2'b10 : 2'b01;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      id             <= 1'b0;
      count          <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_id    <= 1'b0;
      bus.resp_err   <= 1'b0;
      fpu_a          <= '0;
      fpu_b          <= '0;
      fpu_opcode     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            last_grant <= grant;
            id         <= grant;
            if (grant_op == OP_DIV) begin
              // Answered locally; the fpu inputs keep the previous operation.
              bus.resp_data  <= QNAN;
              bus.resp_err   <= 1'b1;
              bus.resp_id    <= grant;
              bus.resp_valid <= 1'b1;
              state          <= RESP;
            end else begin
              fpu_a      <= grant_a;
              fpu_b      <= grant_b;
              fpu_opcode <= grant_op;
              count      <= '0;
              state      <= WAIT;
            end
          end
        end
        WAIT: begin
          // count reaches FPU_LATENCY one edge after fpu_o became valid,
          // so WAIT spans FPU_LATENCY+1 cycles.
          count <= count + CNT_W'(1);
          if (count == CNT_W'(FPU_LATENCY)) begin
            bus.resp_data  <= fpu_o;
            bus.resp_err   <= 1'b0;
            bus.resp_id    <= id;
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed plus randomized bench for fpu_arbiter, checked
// against a transaction-level reference model; a second FPU_LATENCY=3
// instance covers the longer wait.
module tb_fpu_arbiter;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;
  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_RESP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  fpu_arbiter_if bus ();
  fpu_arbiter_if bus3 ();

  logic [31:0] fpu_a, fpu_b, fpu_o, fpu3_a, fpu3_b, fpu3_o;
  logic [1:0]  fpu_opcode, fpu3_opcode;
  logic        busy, busy3;

  fpu_arbiter #(.FPU_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode),
    .fpu_o(fpu_o), .busy(busy)
  );

  fpu_arbiter #(.FPU_LATENCY(LAT3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3),
    .fpu_a(fpu3_a), .fpu_b(fpu3_b), .fpu_opcode(fpu3_opcode),
    .fpu_o(fpu3_o), .busy(busy3)
  );

  // Single-precision <-> real helpers (normal numbers and zero only).
  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) return 0.0;
    d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52];
    return {d[63], 8'(e - 11'd896), d[51:29]};
  endfunction

  // Behaviour of the external fpu; it has no divider.
  function automatic logic [31:0] fpu_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
    case (op)
      2'b00:   return r2f(f2r(a) + f2r(b));
      2'b01:   return r2f(f2r(a) - f2r(b));
      2'b11:   return r2f(f2r(a) * f2r(b));
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [31:0] rnd_f();
    return r2f($itor($urandom_range(1, 200)));
  endfunction

  // fpu stand-ins: result valid LAT edges after the inputs settle.
  logic [31:0] pipe1 [LAT];
  logic [31:0] pipe3 [LAT3];
  always @(posedge clk) begin
    pipe1[0] <= fpu_calc(fpu_a, fpu_b, fpu_opcode);
    for (int i = 1; i < LAT; i++) pipe1[i] <= pipe1[i-1];
  end
  always @(posedge clk) begin
    pipe3[0] <= fpu_calc(fpu3_a, fpu3_b, fpu3_opcode);
    for (int i = 1; i < LAT3; i++) pipe3[i] <= pipe3[i-1];
  end
  assign fpu_o  = pipe1[LAT-1];
  assign fpu3_o = pipe3[LAT3-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state: one transaction in flight at most.
  int          m_phase = M_IDLE;
  int          m_left  = 0;
  logic        m_last  = 1'b1;
  logic [31:0] m_data  = 32'd0;
  logic        m_id    = 1'b0;
  logic        m_err   = 1'b0;
  logic [31:0] m_fa    = 32'd0;
  logic [31:0] m_fb    = 32'd0;
  logic [1:0]  m_fop   = 2'b00;
  logic [1:0]  m_acc   = 2'b00;

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
    bus.req_op[2*i +: 2]  = op;
  endtask

  // Called just after a falling edge with inputs applied: checks the grant,
  // advances the model over the next rising edge, then checks the outputs.
  task automatic step(input logic do_rst);
    logic        acc;
    logic        g;
    logic [1:0]  exp_rdy;
    logic [1:0]  op;
    logic [31:0] a, b;
    #1;
    acc = (m_phase == M_IDLE) && (bus.req_valid != 2'b00);
    if (bus.req_valid == 2'b11) g = (m_last == 1'b0);
    else                        g = (bus.req_valid == 2'b10);
    exp_rdy = acc ? (g ? 2'b10 : 2'b01) : 2'b00;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    m_acc = do_rst ? 2'b00 : exp_rdy;
    if (do_rst) begin
      m_phase = M_IDLE; m_last = 1'b1; m_left = 0;
      m_data = 32'd0; m_id = 1'b0; m_err = 1'b0;
      m_fa = 32'd0; m_fb = 32'd0; m_fop = 2'b00;
    end else if (acc) begin
      a = bus.req_a[32*g +: 32];
      b = bus.req_b[32*g +: 32];
      op = bus.req_op[2*g +: 2];
      m_last = g;
      m_id = g;
      if (op == 2'b10) begin
        m_data = 32'h7FC0_0000; m_err = 1'b1; m_phase = M_RESP;
      end else begin
        m_fa = a; m_fb = b; m_fop = op;
        m_data = fpu_calc(a, b, op); m_err = 1'b0;
        m_phase = M_WAIT; m_left = LAT + 1;
      end
    end else if (m_phase == M_WAIT) begin
      m_left--;
      if (m_left == 0) m_phase = M_RESP;
    end else if (m_phase == M_RESP && bus.resp_ready) begin
      m_phase = M_IDLE;
    end
    rst = do_rst;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("resp_valid", 32'(bus.resp_valid), 32'(m_phase == M_RESP));
    chk("busy", 32'(busy), 32'(m_phase != M_IDLE));
    if (m_phase == M_RESP) begin
      chk("resp_data", bus.resp_data, m_data);
      chk("resp_id", 32'(bus.resp_id), 32'(m_id));
      chk("resp_err", 32'(bus.resp_err), 32'(m_err));
    end
    chk("fpu_a", fpu_a, m_fa);
    chk("fpu_b", fpu_b, m_fb);
    chk("fpu_opcode", 32'(fpu_opcode), 32'(m_fop));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nr;
    logic        ids [4];
    logic [31:0] datas [4];
    int          edges;

    bus.req_valid = 2'b00; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
    bus.resp_ready = 1'b1;
    bus3.req_valid = 2'b00; bus3.req_a = '0; bus3.req_b = '0; bus3.req_op = '0;
    bus3.resp_ready = 1'b1;
    @(negedge clk);

    // Reset state
    step(1'b1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_fpu_a", fpu_a, 32'd0);
    chk("rst_fpu_op", 32'(fpu_opcode), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single ADD 1.0 + 2.0
    set_req(0, 2'b00, 32'h3F80_0000, 32'h4000_0000);
    bus.req_valid = 2'b01;
    step(1'b0);
    bus.req_valid = 2'b00;
    step(1'b0);
    chk("add_early", 32'(bus.resp_valid), 32'd0);
    step(1'b0);
    chk("add_valid", 32'(bus.resp_valid), 32'd1);
    chk("add_data", bus.resp_data, 32'h4040_0000);
    chk("add_id", 32'(bus.resp_id), 32'd0);
    chk("add_err", 32'(bus.resp_err), 32'd0);
    step(1'b0);

    // Contention after reset: req0 first, then alternating
    step(1'b1);
    set_req(0, 2'b01, 32'h4040_0000, 32'h3F80_0000);
    set_req(1, 2'b11, 32'h4000_0000, 32'h4040_0000);
    bus.req_valid = 2'b11;
    nr = 0;
    for (int k = 0; k < 60 && nr < 4; k++) begin
      step(1'b0);
      if (bus.resp_valid) begin
        ids[nr] = bus.resp_id;
        datas[nr] = bus.resp_data;
        nr++;
      end
    end
    chk("rr_count", 32'(nr), 32'd4);
    if (nr == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("rr_id", 32'(ids[k]), 32'(k % 2));
        chk("rr_data", datas[k], (k % 2 == 0) ? 32'h4000_0000 : 32'h40C0_0000);
      end
    end
    bus.req_valid = 2'b00;
    step(1'b0);

    // DIV from req1: answered locally, fpu keeps the previous MUL
    set_req(1, 2'b10, rnd_f(), rnd_f());
    bus.req_valid = 2'b10;
    step(1'b0);
    bus.req_valid = 2'b00;
    chk("div_valid", 32'(bus.resp_valid), 32'd1);
    chk("div_data", bus.resp_data, 32'h7FC0_0000);
    chk("div_id", 32'(bus.resp_id), 32'd1);
    chk("div_err", 32'(bus.resp_err), 32'd1);
    chk("div_fpu_op", 32'(fpu_opcode), 32'(2'b11));
    step(1'b0);

    // Backpressure in RESP with req0 waiting
    set_req(0, 2'b00, 32'h3F80_0000, 32'h4000_0000);
    bus.req_valid = 2'b01;
    bus.resp_ready = 1'b0;
    step(1'b0);
    bus.req_valid = 2'b00;
    for (int k = 0; k < 10 && !bus.resp_valid; k++) step(1'b0);
    chk("bp_reach", 32'(bus.resp_valid), 32'd1);
    set_req(0, 2'b11, 32'h4000_0000, 32'h4040_0000);
    bus.req_valid = 2'b01;
    repeat (5) begin
      step(1'b0);
      chk("bp_data", bus.resp_data, 32'h4040_0000);
      chk("bp_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    bus.resp_ready = 1'b1;
    step(1'b0);
    #1;
    chk("bp_next_accept", 32'(bus.req_ready), 32'(2'b01));
    step(1'b0);
    bus.req_valid = 2'b00;
    for (int k = 0; k < 10 && !bus.resp_valid; k++) step(1'b0);
    chk("bp_next_data", bus.resp_data, 32'h40C0_0000);
    step(1'b0);

    // Reset during WAIT discards the operation
    set_req(0, 2'b00, 32'h3F80_0000, 32'h4000_0000);
    bus.req_valid = 2'b01;
    step(1'b0);
    bus.req_valid = 2'b00;
    step(1'b0);
    step(1'b1);
    chk("rw_valid", 32'(bus.resp_valid), 32'd0);
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_fpu_a", fpu_a, 32'd0);
    chk("rw_fpu_b", fpu_b, 32'd0);
    repeat (4) begin
      step(1'b0);
      chk("rw_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    set_req(1, 2'b00, 32'h4000_0000, 32'h4040_0000);
    bus.req_valid = 2'b10;
    step(1'b0);
    bus.req_valid = 2'b00;
    for (int k = 0; k < 10 && !bus.resp_valid; k++) step(1'b0);
    chk("rw_after_data", bus.resp_data, 32'h40A0_0000);
    chk("rw_after_id", 32'(bus.resp_id), 32'd1);
    step(1'b0);

    // Randomized traffic with requester hold rules and random backpressure
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (bus.req_valid[i] && !m_acc[i]) begin
          if ($urandom_range(0, 3) == 0) bus.req_valid[i] = 1'b0;
        end else begin
          bus.req_valid[i] = 1'($urandom_range(0, 1));
          set_req(i, 2'($urandom_range(0, 3)), rnd_f(), rnd_f());
        end
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      step(1'b0);
    end
    bus.req_valid = 2'b00;
    bus.resp_ready = 1'b1;
    step(1'b0);
    step(1'b0);

    // FPU_LATENCY=3 instance: 3.0 * 2.0 after 4 edges, inputs held
    bus3.req_a[31:0] = 32'h4000_0000;
    bus3.req_b[31:0] = 32'h4040_0000;
    bus3.req_op[1:0] = 2'b11;
    bus3.req_valid = 2'b01;
    #1;
    chk("l3_ready", 32'(bus3.req_ready), 32'(2'b01));
    @(posedge clk);
    @(negedge clk);
    bus3.req_valid = 2'b00;
    edges = 0;
    while (!bus3.resp_valid && edges < 20) begin
      chk("l3_fpu_a", fpu3_a, 32'h4000_0000);
      chk("l3_fpu_b", fpu3_b, 32'h4040_0000);
      chk("l3_fpu_op", 32'(fpu3_opcode), 32'(2'b11));
      chk("l3_busy", 32'(busy3), 32'd1);
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    chk("l3_latency", 32'(edges), 32'd4);
    chk("l3_data", bus3.resp_data, 32'h40C0_0000);
    chk("l3_id", 32'(bus3.resp_id), 32'd0);
    chk("l3_err", 32'(bus3.resp_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("l3_done", 32'(bus3.resp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
Shares one fpu instance between two requesters over valid/ready handshakes. The block arbitrates round-robin and registers the winning operands and opcode. It holds those inputs on the fpu stable, waits the fpu latency, captures O and returns it with the requester id. DIV (opcode 2'b10) has no FPU datapath, so the block answers it locally with a quiet NaN and an error flag. The block sits between the issuing units and the fpu, and is the only driver of fpu A/B/opcode.

Parameters:
FPU_LATENCY, 1, clock edges from stable fpu inputs to valid fpu O; legal range >=1.

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  synchronous reset, active-high; one clock; reset is synchronous and active-high
req_valid  input  2  bit i: requester i presents an operation
req_ready  output  2  bit i: requester i accepted this cycle (combinational, at most one bit set)
req_a  input  64  operand A, [32i+31:32i] for requester i
req_b  input  64  operand B, same packing
req_op  input  4  opcode [2i+1:2i]; 00 ADD, 01 SUB, 10 DIV, 11 MUL
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
resp_data  output  32  IEEE-754 single result
resp_id  output  1  requester index of the result
resp_err  output  1  1 = unsupported op (DIV)
fpu_a  output  32  to fpu A
fpu_b  output  32  to fpu B
fpu_opcode  output  2  to fpu opcode
fpu_o  input  32  from fpu O
busy  output  1  state != IDLE

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, last_grant=1, wait count=0.
  - resp_valid=0, resp_data=0, resp_id=0, resp_err=0.
  - fpu_a=0, fpu_b=0, fpu_opcode=2'b00; busy=0.
  - Applies in any state: an in-flight op is discarded and never responded to.
- States: IDLE, WAIT, RESP.
- IDLE, grant:
  - req_ready=0 outside IDLE.
  - In IDLE with one valid, that requester is granted.
  - With both valid, the requester != last_grant is granted.
  - req_ready[g]=1 combinationally. The accept edge loads last_grant=g and id=g.
- IDLE, non-DIV op: on accept, fpu_a/fpu_b/fpu_opcode load from requester g, count=0, next=WAIT.
- IDLE, DIV op: on accept, fpu_* are unchanged and next=RESP with resp_data=32'h7FC00000, resp_err=1, resp_id=g. resp_valid is seen one edge after accept.
- WAIT:
  - fpu_* are held constant.
  - Each edge increments count.
  - On the edge where count==FPU_LATENCY: resp_data<=fpu_o, resp_err<=0, resp_id<=id, next=RESP.
  - WAIT lasts exactly FPU_LATENCY+1 cycles. resp_valid rises FPU_LATENCY+1 edges after the accept edge (2 for default).
- RESP:
  - resp_valid=1.
  - resp_data/resp_id/resp_err are stable until the edge where resp_valid&&resp_ready, then next=IDLE.
  - No new accept occurs in RESP; the earliest next accept is the cycle after handshake.
- Requester rules: requesters hold valid/a/b/op until ready. Deasserting valid before ready is permitted and simply loses arbitration. Accepted data is registered, so requester inputs may change after accept.
- Count width: clog2(FPU_LATENCY+1)+1 bits. Opcode passes to the fpu unmodified (SUB negation stays inside the fpu).
- Throughput: one op per FPU_LATENCY+3 cycles minimum, with no pipelining or reordering.
- fpu_* outputs never change outside IDLE accept edges or reset.

Test Plan:
- After reset, req0 ADD a=0x3F800000 b=0x40000000 -> req_ready=01 same cycle; resp_valid 2 edges later; resp_data=0x40400000, id=0, err=0.
- Both valid after reset: req0 SUB 0x40400000-0x3F800000, req1 MUL 0x40000000*0x40400000 -> req0 served first (0x40000000, id 0), then req1 (0x40C00000, id 1). With both held valid, grants alternate 0,1,0,1.
- req1 DIV any operands -> resp one edge after accept: 0x7FC00000, id=1, err=1. fpu_opcode is unchanged from the prior op.
- Backpressure: resp_ready=0 for 5 cycles in RESP with req0 valid -> resp_* stable, req_ready=00, busy=1. Handshake returns to IDLE and the next accept follows.
- rst=1 for one cycle during WAIT -> next cycle: IDLE, resp_valid=0, fpu_*=0, busy=0. The pending result never appears; a subsequent req1 ADD completes normally.
- FPU_LATENCY=3 build -> resp_valid rises 4 edges after accept; fpu_a/b/opcode are constant throughout WAIT.
